// File: rtl/cpa_arb_pkg.sv
// Shared types and width helpers for the shared-CPA arbiter block.
// The default widths describe the standard 32-bit, four-lane configuration.
package cpa_arb_pkg;

  localparam int CPA_BITS = 32;
  localparam int CPA_NREQ = 4;

  function automatic int cpa_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CPA_IDW = cpa_idw(CPA_NREQ);

  typedef struct packed {
    logic [CPA_BITS-1:0] a;
    logic [CPA_BITS-1:0] b;
    logic [CPA_IDW-1:0]  id;
  } cpa_op_t;

  typedef struct packed {
    logic [CPA_BITS-1:0] sum;
    logic                co;
    logic [CPA_IDW-1:0]  id;
  } cpa_rsp_t;

endpackage

// File: rtl/cpa_rr_arbiter.sv
// Round-robin requester scan starting at ptr; emits a one-hot grant and the winner index.
// Define CPA_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (ptr is then ignored).
module cpa_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  winner,
  output logic            found
);

`ifdef CPA_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    // Descending scan: the last hit written is the lowest index.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = IDW'(i);
        found  = 1'b1;
      end
    end
    if (en && found) grant[winner] = 1'b1;
  end
`else
  always_comb begin
    int               s;
    logic [IDW-1:0]   idx;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    s      = 0;
    idx    = '0;
    // Descending scan: the last hit written is the first one at or after ptr.
    for (int k = NREQ - 1; k >= 0; k--) begin
      s   = (int'(ptr) + k) % NREQ;
      idx = IDW'(s);
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    if (en && found) grant[winner] = 1'b1;
  end
`endif

endmodule

// File: rtl/cpa_share_arbiter.sv
// One carry-propagate adder shared by NREQ requesters: arbiter -> operand reg -> CPA -> result reg.
// CPA_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin; default is round-robin.
module cpa_share_arbiter
  import cpa_arb_pkg::*;
#(
  parameter int BITS = 32,
  parameter int NREQ = 4,
  parameter int IDW  = cpa_idw(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BITS-1:0] req_a,
  input  logic [NREQ*BITS-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [BITS-1:0]      rsp_sum,
  output logic                 rsp_co
);

  logic            s1_valid;
  logic [BITS-1:0] s1_a;
  logic [BITS-1:0] s1_b;
  logic [IDW-1:0]  s1_id;

  logic            s2_adv;
  logic            s1_adv;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  winner;
  logic            found;
  logic            accept;
  logic [BITS:0]   cpa_out;

  assign s2_adv = !rsp_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Gating with rst_n drops every ready the moment reset asserts.
  cpa_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (s1_adv && rst_n),
    .grant  (grant),
    .winner (winner),
    .found  (found)
  );

  assign req_ready = grant;
  assign accept    = |grant;

`ifdef CPA_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end
`endif

  // ---- S1: operand capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a  <= req_a[int'(winner)*BITS +: BITS];
      s1_b  <= req_b[int'(winner)*BITS +: BITS];
      s1_id <= winner;
    end
  end

  // ---- CPA between S1 and S2, carry-in tied low ----
  assign cpa_out = {1'b0, s1_a} + {1'b0, s1_b};

  // ---- S2: result register / response port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_co    <= 1'b0;
      rsp_id    <= '0;
    end else if (s2_adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        {rsp_co, rsp_sum} <= cpa_out;
        rsp_id            <= s1_id;
      end
    end
  end

  logic unused_found;
  assign unused_found = found;

endmodule

// File: tb/tb_cpa_share_arbiter.sv
// Directed bench for cpa_share_arbiter: reset, latency, rotation, backpressure, async reset, random soak.
module tb_cpa_share_arbiter;

  localparam int BITS = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BITS-1:0] req_a;
  logic [NREQ*BITS-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [BITS-1:0]      rsp_sum;
  logic                 rsp_co;

  int n_cmp = 0;
  int n_bad = 0;

  cpa_share_arbiter #(.BITS(BITS), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_co    (rsp_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BITS:0] ref_add(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic set_op(input int i, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    req_a[i*BITS +: BITS] = a;
    req_b[i*BITS +: BITS] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (rsp_sum !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_sum: got %h expected 0", rsp_sum); end
    n_cmp++; if (rsp_co !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_co: got %b expected 0", rsp_co); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    set_op(2, 32'hFFFF_FFFF, 32'h1);
    req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b expected 0", rsp_valid); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b expected 1", rsp_valid); end
    n_cmp++; if (rsp_sum !== 32'h0) begin n_bad++; $display("FAIL single_sum: got %h expected 00000000", rsp_sum); end
    n_cmp++; if (rsp_co !== 1'b1) begin n_bad++; $display("FAIL single_co: got %b expected 1", rsp_co); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL single_id: got %0d expected 2", rsp_id); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_dup: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [IDW-1:0] exp_id [6];
    logic [BITS:0]  exp;
    int             got;
    bit             started;
`ifdef CPA_ARB_FIXED_PRIO_EN
    exp_id = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h8000_0000 + i, 32'h8000_0000 + 16 * i);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    got = 0;
    started = 1'b0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      @(negedge clk);
      if (started || rsp_valid) begin
        started = 1'b1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rr_bubble[%0d]: got %b expected 1", got, rsp_valid); end
        if (rsp_valid === 1'b1) begin
          exp = ref_add(32'h8000_0000 + exp_id[got], 32'h8000_0000 + 16 * exp_id[got]);
          n_cmp++; if (rsp_id !== exp_id[got]) begin n_bad++; $display("FAIL rr_id[%0d]: got %0d expected %0d", got, rsp_id, exp_id[got]); end
          n_cmp++; if ({rsp_co, rsp_sum} !== exp) begin n_bad++; $display("FAIL rr_sum[%0d]: got %h expected %h", got, {rsp_co, rsp_sum}, exp); end
          got++;
        end
      end
    end
    n_cmp++; if (got !== 6) begin n_bad++; $display("FAIL rr_count: got %0d expected 6", got); end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_backpressure();
    do_reset();
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_op(0, 32'd5, 32'd7);
    set_op(1, 32'hFFFF_FFF0, 32'h20);
    set_op(2, 32'd100, 32'd200);
    req_valid = 4'b0011;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_ready0: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0110;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_ready1: got %b expected 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", c, req_ready); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_sum !== 32'd12 || rsp_id !== 2'd0) begin
        n_bad++; $display("FAIL bp_hold[%0d]: got v=%b sum=%h id=%0d expected v=1 sum=0000000c id=0", c, rsp_valid, rsp_sum, rsp_id);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_refill_ready: got %b expected 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_id, rsp_co, rsp_sum} !== {1'b1, 2'd1, 1'b1, 32'h10}) begin
      n_bad++; $display("FAIL bp_drain1: got v=%b id=%0d co=%b sum=%h expected v=1 id=1 co=1 sum=00000010", rsp_valid, rsp_id, rsp_co, rsp_sum);
    end
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_id, rsp_co, rsp_sum} !== {1'b1, 2'd2, 1'b0, 32'd300}) begin
      n_bad++; $display("FAIL bp_drain2: got v=%b id=%0d co=%b sum=%h expected v=1 id=2 co=0 sum=0000012c", rsp_valid, rsp_id, rsp_co, rsp_sum);
    end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_nodup: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_rr_skip();
    logic [NREQ-1:0] exp_first;
`ifdef CPA_ARB_FIXED_PRIO_EN
    exp_first = 4'b0010;
`else
    exp_first = 4'b1000;
`endif
    do_reset();
    @(posedge clk); #1;
    set_op(1, 32'd1, 32'd2);
    set_op(3, 32'd3, 32'd4);
    req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL skip_prime: got %b expected 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 req_valid = 4'b1010;
    @(negedge clk);
    n_cmp++; if (req_ready !== exp_first) begin n_bad++; $display("FAIL skip_first: got %b expected %b", req_ready, exp_first); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL skip_second: got %b expected 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL skip_stream[%0d]: got %b expected 0010", c, req_ready); end
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h10 * i, 32'h3);
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL ar_prefill: got %b expected 1", rsp_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL ar_rsp_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL ar_ready: got %b expected 0000", req_ready); end
    n_cmp++; if (rsp_sum !== 32'h0) begin n_bad++; $display("FAIL ar_sum: got %h expected 0", rsp_sum); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL ar_first_grant: got %b expected 0001", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL ar_no_replay: got %b expected 0", rsp_valid); end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_random();
    logic [BITS-1:0]        ca [NREQ];
    logic [BITS-1:0]        cb [NREQ];
    logic [IDW+BITS:0]      expq [$];
    logic [IDW+BITS:0]      head;
    logic [NREQ-1:0]        acc;
    int                     accepted;
    int                     cyc;
    localparam int          TARGET = 10000;
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      ca[i] = $urandom;
      cb[i] = $urandom;
      set_op(i, ca[i], cb[i]);
      req_valid[i] = ($urandom_range(0, 3) != 0);
    end
    accepted = 0;
    cyc = 0;
    while ((accepted < TARGET || expq.size() != 0 || rsp_valid) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      acc = req_valid & req_ready;
      n_cmp++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
        n_bad++; $display("FAIL rnd_ready_onehot: got ready=%b valid=%b expected one-hot subset", req_ready, req_valid);
      end
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++; $display("FAIL rnd_spurious: got id=%0d sum=%h expected no response", rsp_id, rsp_sum);
        end else begin
          head = expq.pop_front();
          if ({rsp_id, rsp_co, rsp_sum} !== head) begin
            n_bad++; $display("FAIL rnd_rsp: got id=%0d cs=%h expected id=%0d cs=%h", rsp_id, {rsp_co, rsp_sum}, head[IDW+BITS:BITS+1], head[BITS:0]);
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          expq.push_back({IDW'(i), ref_add(ca[i], cb[i])});
          accepted++;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] || !req_valid[i]) begin
          ca[i] = $urandom;
          cb[i] = $urandom;
          set_op(i, ca[i], cb[i]);
          req_valid[i] = (accepted < TARGET) && ($urandom_range(0, 3) != 0);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    n_cmp++; if (cyc >= 60000) begin n_bad++; $display("FAIL rnd_timeout: got %0d cycles expected < 60000", cyc); end
    n_cmp++; if (accepted < TARGET) begin n_bad++; $display("FAIL rnd_accepted: got %0d expected >= %0d", accepted, TARGET); end
    n_cmp++; if (expq.size() != 0) begin n_bad++; $display("FAIL rnd_lost: got %0d pending expected 0", expq.size()); end
    req_valid = '0;
    rsp_ready = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_rr_skip();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
